// File: rtl/modport_stream_adapter.sv
// Registered stream stage with a two-entry skid buffer, packet framing checker
// and a small memory-mapped control/status block (enable plus three counters).
module modport_stream_adapter #(
  parameter int DAT_BYTS  = 8,
  parameter int DAT_BITS  = DAT_BYTS*8,
  parameter int CTL_BITS  = 8,
  parameter int MOD_BITS  = (DAT_BYTS == 1) ? 1 : $clog2(DAT_BYTS),
  parameter int MM_D_BITS = 64,
  parameter int MM_A_BITS = 8
)(
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_val,
  input  logic                 i_err,
  input  logic                 i_sop,
  input  logic                 i_eop,
  input  logic [CTL_BITS-1:0]  i_ctl,
  input  logic [DAT_BITS-1:0]  i_dat,
  input  logic [MOD_BITS-1:0]  i_mod,
  output logic                 o_rdy,
  output logic                 o_val,
  output logic                 o_err,
  output logic                 o_sop,
  output logic                 o_eop,
  output logic [CTL_BITS-1:0]  o_ctl,
  output logic [DAT_BITS-1:0]  o_dat,
  output logic [MOD_BITS-1:0]  o_mod,
  input  logic                 i_rdy,
  input  logic [MM_A_BITS-1:0] i_mm_addr,
  input  logic [MM_D_BITS-1:0] i_mm_wr_dat,
  input  logic                 i_mm_wr,
  input  logic                 i_mm_rd,
  output logic [MM_D_BITS-1:0] o_mm_rd_dat,
  output logic                 o_mm_rd_dat_val,
  output logic                 o_mm_wait_rq
);

  typedef struct packed {
    logic                err;
    logic                sop;
    logic                eop;
    logic [CTL_BITS-1:0] ctl;
    logic [DAT_BITS-1:0] dat;
    logic [MOD_BITS-1:0] mod;
  } beat_t;

  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

  beat_t in_beat, out_q, skid_q;
  logic  out_vld, skid_full, rdy_q, ctrl_en, in_pkt;
  logic  acc, fwd, sop_in_pkt, orphan, drain;
  logic  ld_skid2out, ld_new2out, ld_skid;
  logic  out_vld_nxt, skid_nxt, ctrl_nxt;
  logic  wr_ctrl, wr_pkt, wr_beat, wr_err;
  logic [31:0]          pkt_cnt, beat_cnt, err_cnt;
  logic [MM_D_BITS-1:0] rd_mux, rd_dat_q;
  logic                 rd_val_q;
  logic                 unused_wr_dat;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == CNT_MAX) ? v : v + 32'd1;
  endfunction

  assign acc        = i_val && rdy_q;
  assign fwd        = acc && ctrl_en && (i_sop || in_pkt);
  assign sop_in_pkt = acc && ctrl_en && i_sop && in_pkt;
  assign orphan     = acc && ctrl_en && !i_sop && !in_pkt;
  assign in_beat    = {i_err | sop_in_pkt, i_sop, i_eop, i_ctl, i_dat, i_mod};

  // The skid entry only fills while the output register is stalled; o_rdy
  // drops for the cycle after it fills, so a third beat is never accepted.
  assign drain       = out_vld && i_rdy;
  assign ld_skid2out = drain && skid_full;
  assign ld_new2out  = fwd && (!out_vld || (drain && !skid_full));
  assign ld_skid     = fwd && out_vld && !drain && !skid_full;
  assign out_vld_nxt = ld_skid2out || ld_new2out || (out_vld && !drain);
  assign skid_nxt    = ld_skid || (skid_full && !drain);

  assign wr_ctrl  = i_mm_wr && (i_mm_addr == MM_A_BITS'(0));
  assign wr_pkt   = i_mm_wr && (i_mm_addr == MM_A_BITS'(1));
  assign wr_beat  = i_mm_wr && (i_mm_addr == MM_A_BITS'(2));
  assign wr_err   = i_mm_wr && (i_mm_addr == MM_A_BITS'(3));
  assign ctrl_nxt = wr_ctrl ? i_mm_wr_dat[0] : ctrl_en;
  assign unused_wr_dat = ^i_mm_wr_dat[MM_D_BITS-1:1];

  always_comb begin
    rd_mux = '0;
    case (i_mm_addr)
      MM_A_BITS'(0): rd_mux = MM_D_BITS'(ctrl_en);
      MM_A_BITS'(1): rd_mux = MM_D_BITS'(pkt_cnt);
      MM_A_BITS'(2): rd_mux = MM_D_BITS'(beat_cnt);
      MM_A_BITS'(3): rd_mux = MM_D_BITS'(err_cnt);
      default:       rd_mux = '0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      out_vld   <= 1'b0;
      skid_full <= 1'b0;
      rdy_q     <= 1'b0;
      ctrl_en   <= 1'b1;
      in_pkt    <= 1'b0;
      out_q     <= '0;
      skid_q    <= '0;
      pkt_cnt   <= '0;
      beat_cnt  <= '0;
      err_cnt   <= '0;
      rd_dat_q  <= '0;
      rd_val_q  <= 1'b0;
    end else begin
      out_vld   <= out_vld_nxt;
      skid_full <= skid_nxt;
      // While disabled every beat is swallowed, so keep the input open.
      rdy_q     <= !skid_nxt || !ctrl_nxt;
      ctrl_en   <= ctrl_nxt;
      if (ld_skid2out)     out_q <= skid_q;
      else if (ld_new2out) out_q <= in_beat;
      if (ld_skid) skid_q <= in_beat;
      if (!ctrl_en)  in_pkt <= 1'b0;
      else if (fwd)  in_pkt <= !i_eop;
      // A clearing write takes priority over a same-cycle increment.
      if (wr_pkt)              pkt_cnt  <= '0;
      else if (fwd && i_eop)   pkt_cnt  <= sat_inc(pkt_cnt);
      if (wr_beat)             beat_cnt <= '0;
      else if (fwd)            beat_cnt <= sat_inc(beat_cnt);
      if (wr_err)              err_cnt  <= '0;
      else if (sop_in_pkt || orphan) err_cnt <= sat_inc(err_cnt);
      rd_val_q <= i_mm_rd;
      if (i_mm_rd) rd_dat_q <= rd_mux;
    end
  end

  assign o_rdy           = rdy_q;
  assign o_val           = out_vld;
  assign o_err           = out_q.err;
  assign o_sop           = out_q.sop;
  assign o_eop           = out_q.eop;
  assign o_ctl           = out_q.ctl;
  assign o_dat           = out_q.dat;
  assign o_mod           = out_q.mod;
  assign o_mm_rd_dat     = rd_dat_q;
  assign o_mm_rd_dat_val = rd_val_q;
  assign o_mm_wait_rq    = 1'b0;

endmodule

// File: tb/tb_modport_stream_adapter.sv
// Random and directed stimulus for modport_stream_adapter, checked against a
// queue-based transaction model that is updated on every cycle's handshakes.
module tb_modport_stream_adapter;

  logic        i_clk = 1'b0, i_rst = 1'b1;
  logic        i_val = 1'b0, i_err = 1'b0, i_sop = 1'b0, i_eop = 1'b0;
  logic [7:0]  i_ctl = '0;
  logic [63:0] i_dat = '0;
  logic [2:0]  i_mod = '0;
  logic        o_rdy, o_val, o_err, o_sop, o_eop;
  logic [7:0]  o_ctl;
  logic [63:0] o_dat;
  logic [2:0]  o_mod;
  logic        i_rdy = 1'b1;
  logic [7:0]  i_mm_addr = '0;
  logic [63:0] i_mm_wr_dat = '0;
  logic        i_mm_wr = 1'b0, i_mm_rd = 1'b0;
  logic [63:0] o_mm_rd_dat;
  logic        o_mm_rd_dat_val, o_mm_wait_rq;

  modport_stream_adapter dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_val(i_val), .i_err(i_err), .i_sop(i_sop), .i_eop(i_eop),
    .i_ctl(i_ctl), .i_dat(i_dat), .i_mod(i_mod), .o_rdy(o_rdy),
    .o_val(o_val), .o_err(o_err), .o_sop(o_sop), .o_eop(o_eop),
    .o_ctl(o_ctl), .o_dat(o_dat), .o_mod(o_mod), .i_rdy(i_rdy),
    .i_mm_addr(i_mm_addr), .i_mm_wr_dat(i_mm_wr_dat),
    .i_mm_wr(i_mm_wr), .i_mm_rd(i_mm_rd),
    .o_mm_rd_dat(o_mm_rd_dat), .o_mm_rd_dat_val(o_mm_rd_dat_val),
    .o_mm_wait_rq(o_mm_wait_rq)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic err; logic sop; logic eop;
    logic [7:0] ctl; logic [63:0] dat; logic [2:0] mod;
  } beat_t;

  int    n_cmp = 0, n_err = 0;
  int    bp_mode = 0;  // 0: always ready, 1: 50% ready, 2: never ready
  beat_t q[$];
  bit    m_en = 1'b1, m_in_pkt = 1'b0, rd_pend = 1'b0;
  logic [31:0] m_pkt = '0, m_beat = '0, m_errc = '0;
  logic [63:0] rd_exp = '0;
  int    since_rst = 0, rst_cyc = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] sat(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Reference model: evaluated mid-cycle on the values that the next rising
  // edge will sample.
  always @(negedge i_clk) begin
    if (i_rst) begin
      if (rst_cyc > 0) begin
        chk("rst_o_val", o_val, 0);
        chk("rst_o_rdy", o_rdy, 0);
        chk("rst_rd_val", o_mm_rd_dat_val, 0);
      end
      rst_cyc++;
      q.delete();
      m_en = 1; m_in_pkt = 0; rd_pend = 0;
      m_pkt = 0; m_beat = 0; m_errc = 0;
      since_rst = 0;
    end else begin
      beat_t b;
      rst_cyc = 0;
      chk("o_val_occ", o_val, q.size() != 0);
      if (since_rst == 0) chk("rdy_post_rst", o_rdy, 0);
      else chk("o_rdy", o_rdy, m_en ? (q.size() < 2) : 1);
      chk("wait_rq", o_mm_wait_rq, 0);
      chk("rd_val", o_mm_rd_dat_val, rd_pend);
      if (rd_pend) chk("rd_dat", o_mm_rd_dat, rd_exp);
      rd_pend = i_mm_rd;
      if (i_mm_rd)
        case (i_mm_addr)
          8'd0: rd_exp = 64'(m_en);
          8'd1: rd_exp = 64'(m_pkt);
          8'd2: rd_exp = 64'(m_beat);
          8'd3: rd_exp = 64'(m_errc);
          default: rd_exp = 0;
        endcase
      if (o_val && i_rdy) begin
        if (q.size() == 0) chk("spurious_beat", 1, 0);
        else begin
          b = q.pop_front();
          chk("beat_dat", o_dat, b.dat);
          chk("beat_flags", {o_err, o_sop, o_eop, o_ctl, o_mod},
              {b.err, b.sop, b.eop, b.ctl, b.mod});
        end
      end
      if (!m_en) m_in_pkt = 0;
      else if (i_val && o_rdy) begin
        if (!i_sop && !m_in_pkt) m_errc = sat(m_errc);
        else begin
          if (i_sop && m_in_pkt) m_errc = sat(m_errc);
          q.push_back('{err: i_err | (i_sop & m_in_pkt), sop: i_sop, eop: i_eop,
                        ctl: i_ctl, dat: i_dat, mod: i_mod});
          m_beat = sat(m_beat);
          if (i_eop) m_pkt = sat(m_pkt);
          m_in_pkt = !i_eop;
        end
      end
      if (i_mm_wr)
        case (i_mm_addr)
          8'd0: m_en = i_mm_wr_dat[0];
          8'd1: m_pkt = 0;
          8'd2: m_beat = 0;
          8'd3: m_errc = 0;
          default: ;
        endcase
      if (since_rst < 1000) since_rst++;
    end
  end

  initial begin
    forever begin
      @(posedge i_clk); #1;
      i_rdy = (bp_mode == 0) ? 1'b1 : (bp_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  end

  task automatic tick();
    @(posedge i_clk); #1;
  endtask

  task automatic send_beat(input bit sop, input bit eop, input bit err,
                           input logic [2:0] mod, input logic [63:0] dat);
    bit acc;
    int n = 0;
    i_val = 1; i_sop = sop; i_eop = eop; i_err = err; i_mod = mod; i_dat = dat;
    i_ctl = 8'($urandom);
    do begin
      @(negedge i_clk); acc = o_rdy;
      @(posedge i_clk); #1; n++;
    end while (!acc && n < 300);
    chk("accept_bound", acc, 1);
    i_val = 0;
  endtask

  task automatic send_pkt(input int nbytes);
    int nb = (nbytes + 7) / 8;
    for (int b = 0; b < nb; b++) begin
      send_beat(b == 0, b == nb - 1, ($urandom_range(0, 9) == 0),
                (b == nb - 1) ? 3'(nbytes % 8) : 3'd0, {$urandom, $urandom});
      repeat ($urandom_range(0, 2)) tick();
    end
  endtask

  task automatic mm_write(input logic [7:0] addr, input logic [63:0] dat);
    i_mm_addr = addr; i_mm_wr_dat = dat; i_mm_wr = 1;
    tick();
    i_mm_wr = 0;
  endtask

  task automatic mm_read(input logic [7:0] addr, input logic [63:0] exp, input string tag);
    i_mm_addr = addr; i_mm_rd = 1;
    tick();
    i_mm_rd = 0;
    @(negedge i_clk);
    chk({tag, "_val"}, o_mm_rd_dat_val, 1);
    chk(tag, o_mm_rd_dat, exp);
    @(negedge i_clk);
    chk({tag, "_pulse"}, o_mm_rd_dat_val, 0);
    tick();
  endtask

  task automatic wait_idle();
    int n = 0;
    while (q.size() != 0 && n < 2000) begin tick(); n++; end
    chk("drain_bound", q.size(), 0);
  endtask

  task automatic clr_cnts();
    mm_write(8'd1, 0); mm_write(8'd2, 0); mm_write(8'd3, 0);
  endtask

  initial begin
    repeat (3) @(posedge i_clk);
    #1 i_rst = 0;
    repeat (2) tick();
    mm_read(8'd0, 1, "rst_ctrl");
    mm_read(8'd1, 0, "rst_pkt");
    mm_read(8'd2, 0, "rst_beat");
    mm_read(8'd3, 0, "rst_err");

    // single 3-beat packet at full rate
    send_beat(1, 0, 0, 3'd0, 64'h1111_1111_1111_1111);
    send_beat(0, 0, 0, 3'd0, 64'h2222_2222_2222_2222);
    send_beat(0, 1, 0, 3'd5, 64'h3333_3333_3333_3333);
    wait_idle();
    mm_read(8'd1, 1, "p3_pkt");
    mm_read(8'd2, 3, "p3_beat");
    mm_read(8'd3, 0, "p3_err");
    clr_cnts();

    // random packets under 50% backpressure
    bp_mode = 1;
    for (int p = 0; p < 20; p++) send_pkt($urandom_range(1, 64));
    wait_idle();
    bp_mode = 0;
    mm_read(8'd1, 20, "rnd_pkt");
    mm_read(8'd3, 0, "rnd_err");
    clr_cnts();

    // orphan beat then a normal packet
    send_beat(0, 0, 0, 3'd0, 64'hDEAD_BEEF_0000_0001);
    send_pkt(16);
    wait_idle();
    mm_read(8'd3, 1, "orph_err");
    mm_read(8'd1, 1, "orph_pkt");
    clr_cnts();

    // sop inside a packet
    send_beat(1, 0, 0, 3'd0, 64'hA0);
    send_beat(0, 0, 0, 3'd0, 64'hA1);
    send_beat(1, 0, 0, 3'd0, 64'hA2);
    send_beat(0, 1, 0, 3'd0, 64'hA3);
    wait_idle();
    mm_read(8'd3, 1, "sip_err");
    mm_read(8'd1, 1, "sip_pkt");
    mm_read(8'd2, 4, "sip_beat");
    clr_cnts();

    // disabled: beats swallowed, counters untouched
    mm_write(8'd0, 0);
    mm_read(8'd0, 0, "dis_ctrl");
    send_pkt(24);
    wait_idle();
    mm_read(8'd1, 0, "dis_pkt");
    mm_read(8'd2, 0, "dis_beat");
    mm_read(8'd3, 0, "dis_err");
    mm_write(8'd0, 1);
    send_pkt(8);
    wait_idle();
    mm_write(8'd2, 0);
    mm_read(8'd2, 0, "clr_beat");
    mm_read(8'd7, 0, "unmapped");
    mm_write(8'd7, 64'hFFFF);
    mm_read(8'd0, 1, "unmapped_wr");
    // read and clear of the same register in one cycle returns the old count
    i_mm_wr_dat = 0; i_mm_wr = 1;
    mm_read(8'd1, 1, "rdwr_old");
    i_mm_wr = 0;
    mm_read(8'd1, 0, "rdwr_new");

    // reset with skid full and output stalled
    bp_mode = 2;
    send_beat(1, 0, 0, 3'd0, 64'hB0);
    send_beat(0, 0, 0, 3'd0, 64'hB1);
    tick();
    @(negedge i_clk);
    chk("stall_val", o_val, 1);
    chk("stall_rdy", o_rdy, 0);
    tick();
    i_rst = 1;
    repeat (2) @(posedge i_clk);
    #1 i_rst = 0;
    bp_mode = 0;
    repeat (2) tick();
    mm_read(8'd1, 0, "rr_pkt");
    mm_read(8'd2, 0, "rr_beat");
    mm_read(8'd3, 0, "rr_err");
    send_beat(0, 1, 0, 3'd0, 64'hC0);
    send_pkt(40);
    wait_idle();
    mm_read(8'd3, 1, "rr_orph");
    mm_read(8'd1, 1, "rr_pkt2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
